// File: rtl/sprite_blitter.sv
// Sprite draw sequencer: scans sprite RAM, aligns its 1-cycle read latency,
// offsets by a latched screen origin, clips/keys pixels and drives VGA writes.
module sprite_blitter #(
  parameter int unsigned WIDTH_X         = 4,
  parameter int unsigned WIDTH_Y         = 3,
  parameter int unsigned SPRITE_W        = 10,
  parameter int unsigned SPRITE_H        = 6,
  parameter int unsigned SCREEN_X        = 160,
  parameter int unsigned SCREEN_Y        = 120,
  parameter logic [2:0]  TRANSPARENT     = 3'b000,
  parameter bit          USE_TRANSPARENT = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [7:0]         origin_x,
  input  logic [6:0]         origin_y,
  output logic               busy,
  output logic               done,
  output logic [WIDTH_X-1:0] rom_x,
  output logic [WIDTH_Y-1:0] rom_y,
  input  logic [2:0]         rom_color,
  output logic [7:0]         vga_x,
  output logic [6:0]         vga_y,
  output logic [2:0]         vga_color,
  output logic               vga_plot
);

  localparam logic [WIDTH_X-1:0] LAST_X = WIDTH_X'(SPRITE_W - 1);
  localparam logic [WIDTH_Y-1:0] LAST_Y = WIDTH_Y'(SPRITE_H - 1);

  typedef enum logic [2:0] {IDLE, SCAN, FLUSH1, FLUSH2, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH_X-1:0] rom_x_nxt;
  logic [WIDTH_Y-1:0] rom_y_nxt;
  logic [7:0]         org_x_q;
  logic [6:0]         org_y_q;
  logic               valid_d1;
  logic [WIDTH_X-1:0] x_d1;
  logic [WIDTH_Y-1:0] y_d1;
  logic [8:0]         sx;
  logic [7:0]         sy;
  logic               plot;

  // Next state and scan address
  always_comb begin
    state_nxt = state;
    rom_x_nxt = rom_x;
    rom_y_nxt = rom_y;
    case (state)
      IDLE: begin
        rom_x_nxt = '0;
        rom_y_nxt = '0;
        if (start) state_nxt = SCAN;
      end
      SCAN: begin
        if (rom_x == LAST_X) begin
          rom_x_nxt = '0;
          if (rom_y == LAST_Y) begin
            rom_y_nxt = '0;
            state_nxt = FLUSH1;
          end else begin
            rom_y_nxt = rom_y + WIDTH_Y'(1);
          end
        end else begin
          rom_x_nxt = rom_x + WIDTH_X'(1);
        end
      end
      FLUSH1:  state_nxt = FLUSH2;
      FLUSH2:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage-2 screen coordinates and write decision
  always_comb begin
    sx   = 9'(org_x_q) + 9'(x_d1);
    sy   = 8'(org_y_q) + 8'(y_d1);
    plot = valid_d1 && (sx < 9'(SCREEN_X)) && (sy < 8'(SCREEN_Y)) &&
           !(USE_TRANSPARENT && (rom_color == TRANSPARENT));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      rom_x     <= '0;
      rom_y     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      org_x_q   <= '0;
      org_y_q   <= '0;
      valid_d1  <= 1'b0;
      x_d1      <= '0;
      y_d1      <= '0;
      vga_x     <= '0;
      vga_y     <= '0;
      vga_color <= '0;
      vga_plot  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rom_x    <= rom_x_nxt;
      rom_y    <= rom_y_nxt;
      busy     <= (state_nxt == SCAN) || (state_nxt == FLUSH1) || (state_nxt == FLUSH2);
      done     <= (state_nxt == DONE);
      if (state == IDLE && start) begin
        org_x_q <= origin_x;
        org_y_q <= origin_y;
      end
      valid_d1 <= (state == SCAN);
      x_d1     <= rom_x;
      y_d1     <= rom_y;
      vga_plot <= plot;
      // Pixel bus holds its last value between writes
      if (plot) begin
        vga_x     <= sx[7:0];
        vga_y     <= sy[6:0];
        vga_color <= rom_color;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with a behavioural 1-cycle sprite RAM
// and a second instance that writes transparent pixels.
module tb_sprite_blitter;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] origin_x = '0;
  logic [6:0] origin_y = '0;

  logic       busy, done, vga_plot;
  logic [3:0] rom_x;
  logic [2:0] rom_y, rom_color, vga_color;
  logic [7:0] vga_x;
  logic [6:0] vga_y;

  logic       nt_busy, nt_done, nt_plot;
  logic [3:0] nt_rom_x;
  logic [2:0] nt_rom_y, nt_rom_color, nt_color;
  logic [7:0] nt_x;
  logic [6:0] nt_y;

  int tests = 0;
  int fails = 0;
  int mif_mode = 0;

  always #5 clk = ~clk;

  sprite_blitter dut (
    .clk(clk), .resetn(resetn), .start(start), .origin_x(origin_x), .origin_y(origin_y),
    .busy(busy), .done(done), .rom_x(rom_x), .rom_y(rom_y), .rom_color(rom_color),
    .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_plot(vga_plot)
  );

  sprite_blitter #(.USE_TRANSPARENT(1'b0)) dut_nt (
    .clk(clk), .resetn(resetn), .start(start), .origin_x(origin_x), .origin_y(origin_y),
    .busy(nt_busy), .done(nt_done), .rom_x(nt_rom_x), .rom_y(nt_rom_y), .rom_color(nt_rom_color),
    .vga_x(nt_x), .vga_y(nt_y), .vga_color(nt_color), .vga_plot(nt_plot)
  );

  function automatic logic [2:0] mif(input int mode, input logic [3:0] x, input logic [2:0] y);
    if (mode == 0) return 3'd7;
    return (x == 4'd3 && y == 3'd2) ? 3'd0 : 3'd5;
  endfunction

  // Sprite RAM models: registered read, one cycle of latency
  always @(posedge clk) begin
    rom_color    <= mif(mif_mode, rom_x, rom_y);
    nt_rom_color <= mif(mif_mode, nt_rom_x, nt_rom_y);
  end

  // Statistics gathered by run_draw
  logic [3:0] fb [0:159][0:119];
  int plots, first_k, last_k, done_cnt, done_k, max_x, nt_plots;
  logic [7:0] first_x, last_x;
  logic [6:0] first_y, last_y;
  logic [2:0] first_c, last_c, nt_c23;
  logic busy_e0, busy_at_done, nt_w23;
  logic ab_plot, ab_busy, ab_done;
  int post_abort_events;

  task automatic run_draw(input logic [7:0] ox, input logic [6:0] oy,
                          input int restart_k, input int abort_k);
    for (int i = 0; i < 160; i++)
      for (int j = 0; j < 120; j++) fb[i][j] = 4'h0;
    plots = 0; first_k = -1; last_k = -1; done_cnt = 0; done_k = -1; max_x = 0;
    nt_plots = 0; nt_w23 = 1'b0; nt_c23 = 3'd0; busy_at_done = 1'b1;
    ab_plot = 1'b1; ab_busy = 1'b1; ab_done = 1'b1; post_abort_events = 0;
    first_x = '0; first_y = '0; first_c = '0; last_x = '0; last_y = '0; last_c = '0;
    @(negedge clk);
    origin_x = ox; origin_y = oy; start = 1'b1;
    @(posedge clk);  // E0
    @(negedge clk);
    start = 1'b0;
    busy_e0 = busy;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);  // sampled after edge E(k)
      if (vga_plot) begin
        plots++;
        if (first_k < 0) begin
          first_k = k; first_x = vga_x; first_y = vga_y; first_c = vga_color;
        end
        last_k = k; last_x = vga_x; last_y = vga_y; last_c = vga_color;
        if (int'(vga_x) > max_x) max_x = int'(vga_x);
        if (vga_x < 8'd160 && vga_y < 7'd120) fb[vga_x][vga_y] = {1'b1, vga_color};
      end
      if (nt_plot) begin
        nt_plots++;
        if (nt_x == 8'd23 && nt_y == 7'd32) begin
          nt_w23 = 1'b1; nt_c23 = nt_color;
        end
      end
      if (done) begin
        done_cnt++; done_k = k; busy_at_done = busy;
      end
      if (abort_k > 0 && k > abort_k && (vga_plot || busy || done)) post_abort_events++;
      if (k == restart_k) begin
        origin_x = 8'd50; origin_y = 7'd50; start = 1'b1;
      end
      if (k == restart_k + 1) start = 1'b0;
      if (k == abort_k) begin
        resetn = 1'b0;
        #1;
        ab_plot = vga_plot; ab_busy = busy; ab_done = done;
      end
      if (abort_k > 0 && k == abort_k + 3) resetn = 1'b1;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    #12;
    tests++;
    if ({busy, done, vga_plot} !== 3'b000 || rom_x !== 4'd0 || rom_y !== 3'd0 ||
        vga_x !== 8'd0 || vga_y !== 7'd0 || vga_color !== 3'd0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b done=%b plot=%b rom=(%0d,%0d) vga=(%0d,%0d,%0d) required all 0",
               busy, done, vga_plot, rom_x, rom_y, vga_x, vga_y, vga_color);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_draw;
    mif_mode = 0;
    run_draw(8'd0, 7'd0, -10, -1);
    tests++;
    if (busy_e0 !== 1'b1) begin fails++; $display("FAIL busy_after_e0: got %b required 1", busy_e0); end
    tests++;
    if (plots != 60) begin fails++; $display("FAIL basic_plot_count: got %0d required 60", plots); end
    tests++;
    if (first_k != 2 || {first_x, first_y, first_c} !== {8'd0, 7'd0, 3'd7}) begin
      fails++;
      $display("FAIL basic_first_plot: edge %0d (%0d,%0d,%0d) required edge 2 (0,0,7)", first_k, first_x, first_y, first_c);
    end
    tests++;
    if (last_k != 61 || {last_x, last_y, last_c} !== {8'd9, 7'd5, 3'd7}) begin
      fails++;
      $display("FAIL basic_last_plot: edge %0d (%0d,%0d,%0d) required edge 61 (9,5,7)", last_k, last_x, last_y, last_c);
    end
    tests++;
    if (done_cnt != 1 || done_k != 62 || busy_at_done !== 1'b0) begin
      fails++;
      $display("FAIL basic_done: count %0d edge %0d busy %b required 1 pulse after edge 62 with busy 0",
               done_cnt, done_k, busy_at_done);
    end
  endtask

  task automatic test_transparency;
    mif_mode = 1;
    run_draw(8'd20, 7'd30, -10, -1);
    tests++;
    if (plots != 59) begin fails++; $display("FAIL keyed_plot_count: got %0d required 59", plots); end
    tests++;
    if (fb[23][32] !== 4'h0) begin fails++; $display("FAIL keyed_skip_23_32: got %h required 0 (unwritten)", fb[23][32]); end
    tests++;
    if (fb[22][32] !== 4'hd || fb[24][32] !== 4'hd) begin
      fails++;
      $display("FAIL keyed_neighbours: got %h/%h required d/d (written, colour 5)", fb[22][32], fb[24][32]);
    end
    tests++;
    if (nt_plots != 60) begin fails++; $display("FAIL unkeyed_plot_count: got %0d required 60", nt_plots); end
    tests++;
    if (nt_w23 !== 1'b1 || nt_c23 !== 3'd0) begin
      fails++;
      $display("FAIL unkeyed_23_32: written %b colour %0d required written 1 colour 0", nt_w23, nt_c23);
    end
  endtask

  task automatic test_clipping;
    mif_mode = 0;
    run_draw(8'd155, 7'd117, -10, -1);
    tests++;
    if (plots != 15) begin fails++; $display("FAIL clip_plot_count: got %0d required 15", plots); end
    tests++;
    if (fb[159][119] !== 4'hf || fb[155][117] !== 4'hf) begin
      fails++;
      $display("FAIL clip_corners: got %h/%h required f/f", fb[155][117], fb[159][119]);
    end
    tests++;
    if (done_cnt != 1 || done_k != 62) begin
      fails++;
      $display("FAIL clip_done: count %0d edge %0d required 1 after edge 62", done_cnt, done_k);
    end
  endtask

  task automatic test_start_while_busy;
    mif_mode = 0;
    run_draw(8'd0, 7'd0, 9, -1);
    tests++;
    if (plots != 60 || max_x > 9 || fb[50][50] !== 4'h0) begin
      fails++;
      $display("FAIL restart_ignored: plots %0d max_x %0d fb(50,50) %h required 60, <=9, 0", plots, max_x, fb[50][50]);
    end
    tests++;
    if (done_cnt != 1 || done_k != 62) begin
      fails++;
      $display("FAIL restart_done: count %0d edge %0d required 1 after edge 62", done_cnt, done_k);
    end
  endtask

  task automatic test_reset_mid_scan;
    mif_mode = 0;
    run_draw(8'd0, 7'd0, -10, 29);
    tests++;
    if ({ab_plot, ab_busy, ab_done} !== 3'b000) begin
      fails++;
      $display("FAIL abort_immediate: plot %b busy %b done %b required 000", ab_plot, ab_busy, ab_done);
    end
    tests++;
    if (post_abort_events != 0 || done_cnt != 0) begin
      fails++;
      $display("FAIL abort_quiet: events %0d done %0d required 0 and 0", post_abort_events, done_cnt);
    end
    run_draw(8'd0, 7'd0, -10, -1);
    tests++;
    if (plots != 60 || first_k != 2 || {first_x, first_y} !== {8'd0, 7'd0} || done_k != 62) begin
      fails++;
      $display("FAIL abort_redraw: plots %0d first edge %0d at (%0d,%0d) done edge %0d required 60, 2, (0,0), 62",
               plots, first_k, first_x, first_y, done_k);
    end
  endtask

  initial begin
    test_reset();
    test_basic_draw();
    test_transparency();
    test_clipping();
    test_start_while_busy();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
